pipelined_shifter: RTL

Parametrised, pipelined successor to the combinational 32-bit barrel shifter in the execute path. It shifts a WIDTH-bit operand by a log2(WIDTH)-bit amount in one of SLL/SRL/SRA (plus optional ROL/ROR). It registers the result after every power-of-two stage and carries a sideband tag to the writeback. It exposes a valid/ready handshake on both sides, so it can sit behind issue logic that may stall.

---
 rtl/shifter_pkg.sv | 50 +++++
 rtl/shift_stage.sv | 75 +++++++
 rtl/pipelined_shifter.sv | 110 +++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
//   Shared definitions for the pipelined shifter:
//     - shift_op_e       : operation encodings (SLL/SRL/SRA/ROL/ROR)
//     - stage_payload_t  : per-stage payload carried between pipeline registers
//     - op_is_legal()    : reports whether an op code is implemented in this build
//
//   Optional feature macro: SHIFTER_ROTATE_EN (ROL/ROR legal when defined).
//
//   The payload struct is sized for the largest supported configuration
//   (WIDTH <= MAX_WIDTH, TAG_W <= MAX_TAG_W). Instances use the low bits and
//   keep the upper bits at zero.
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam int MAX_WIDTH   = 128;
    localparam int MAX_SHAMT_W = 7;
    localparam int MAX_TAG_W   = 16;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;

    typedef struct packed {
        logic [MAX_WIDTH-1:0]   data;
        logic [MAX_SHAMT_W-1:0] shamt;    // full shift amount, each stage reads its own bit
        logic [2:0]             op;
        logic                   fill;     // sign of the original operand, captured at entry
        logic [MAX_TAG_W-1:0]   tag;
        logic                   illegal;
    } stage_payload_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: ok = 1'b1;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL, OP_ROR:         ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
//   Combinational single-distance shifter stage. When en is set the payload
//   data is shifted by DIST in the direction implied by op; otherwise it passes
//   through. All other payload fields are forwarded unchanged.
//
//   Parameters: WIDTH (operand width), DIST (shift distance of this stage)
//   Ports:
//     pin  : incoming payload
//     en   : this stage's shift-amount bit
//     pout : outgoing payload
//
//   Optional feature macro: SHIFTER_ROTATE_EN (wrap-around bits for ROL/ROR).
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 16
) (
    input  stage_payload_t pin,
    input  logic           en,
    output stage_payload_t pout
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] l_src;   // candidate bit for a left move
    logic [WIDTH-1:0] r_src;   // candidate bit for a right move
    logic [WIDTH-1:0] res;
    logic             is_left;
    logic             fill_bit;

    assign d        = pin.data[WIDTH-1:0];
    // Only SRA fills with the sign; SRL and illegal ops fill with zero.
    assign fill_bit = (pin.op == OP_SRA) && pin.fill;

`ifdef SHIFTER_ROTATE_EN
    logic rot;
    assign is_left = (pin.op == OP_SLL) || (pin.op == OP_ROL);
    assign rot     = (pin.op == OP_ROL) || (pin.op == OP_ROR);
`else
    assign is_left = (pin.op == OP_SLL);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= DIST) begin : g_l_in
            assign l_src[i] = d[i-DIST];
        end else begin : g_l_edge
`ifdef SHIFTER_ROTATE_EN
            assign l_src[i] = rot ? d[i+WIDTH-DIST] : 1'b0;
`else
            assign l_src[i] = 1'b0;
`endif
        end

        if (i + DIST < WIDTH) begin : g_r_in
            assign r_src[i] = d[i+DIST];
        end else begin : g_r_edge
`ifdef SHIFTER_ROTATE_EN
            assign r_src[i] = rot ? d[i+DIST-WIDTH] : fill_bit;
`else
            assign r_src[i] = fill_bit;
`endif
        end

        // mux2 pair: direction select, then shift/pass select
        assign res[i] = en ? (is_left ? l_src[i] : r_src[i]) : d[i];
    end

    always_comb begin
        pout                  = pin;
        pout.data[WIDTH-1:0]  = res;
    end

endmodule

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
//   WIDTH-bit shifter split into log2(WIDTH) registered stages. Stage j shifts
//   by WIDTH>>(j+1) when shamt bit N-1-j is set. A sideband tag rides along.
//   Valid/ready on both sides with a single global stall: every stage register
//   loads only when the output slot is free or being consumed.
//
//   Parameters: WIDTH (8..128, power of two), TAG_W (1..MAX_TAG_W)
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     flush                           drop all in-flight operations
//     in_valid/in_ready               input handshake
//     in_data, in_shamt, in_op, in_tag operation
//     out_valid/out_ready             output handshake
//     out_data, out_tag, out_illegal  result (out_data=0 for illegal ops)
//
//   Optional feature macro: SHIFTER_ROTATE_EN (adds ROL/ROR).
// -----------------------------------------------------------------------------
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_illegal
);

    localparam int N = $clog2(WIDTH);

    logic           advance;
    logic           accept;
    logic [N:1]     vld_pipe;      // vld_pipe[j+1] qualifies stage_q[j]
    stage_payload_t entry;
    stage_payload_t stage_in [N];
    stage_payload_t stage_d  [N];
    stage_payload_t stage_q  [N];

    assign advance  = !vld_pipe[N] || out_ready;
    // An op offered alongside flush would otherwise slip in after the clear.
    assign in_ready = advance && !flush;
    assign accept   = in_valid && in_ready;

    // Illegal ops enter with zero data and a zero fill source path, so every
    // stage keeps them at zero and the result needs no output mux.
    always_comb begin
        entry                   = '0;
        entry.data[WIDTH-1:0]   = op_is_legal(in_op) ? in_data : '0;
        entry.shamt[N-1:0]      = in_shamt;
        entry.op                = in_op;
        entry.fill              = in_data[WIDTH-1];
        entry.tag[TAG_W-1:0]    = in_tag;
        entry.illegal           = !op_is_legal(in_op);
    end

    for (genvar j = 0; j < N; j++) begin : g_stage
        if (j == 0) begin : g_first
            assign stage_in[j] = entry;
        end else begin : g_next
            assign stage_in[j] = stage_q[j-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (WIDTH >> (j + 1))
        ) u_stage (
            .pin  (stage_in[j]),
            .en   (stage_in[j].shamt[N-1-j]),
            .pout (stage_d[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int j = 0; j < N; j++) stage_q[j] <= '0;
        end else begin
            // flush wins over stall
            if (flush)        vld_pipe <= '0;
            else if (advance) vld_pipe <= {vld_pipe[N-1:1], accept};

            // bubbles load too; their data is never observed as valid
            if (advance) begin
                for (int j = 0; j < N; j++) stage_q[j] <= stage_d[j];
            end
        end
    end

    assign out_valid   = vld_pipe[N];
    assign out_data    = stage_q[N-1].data[WIDTH-1:0];
    assign out_tag     = stage_q[N-1].tag[TAG_W-1:0];
    assign out_illegal = stage_q[N-1].illegal;

    // Shamt/op/fill and the upper pad bits of the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^stage_q[N-1];

endmodule
